// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the processor's fetch/data ports, the arbiter and the shared memory.
// The slave modport is the arbiter's view; master is the surrounding core/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  imem_req_i;
    logic [ADDR_WIDTH-1:0] imem_addr_i;
    logic [DATA_WIDTH-1:0] imem_rdata_o;
    logic                  imem_ack_o;
    logic                  dmem_req_i;
    logic                  dmem_we_i;
    logic [ADDR_WIDTH-1:0] dmem_addr_i;
    logic [DATA_WIDTH-1:0] dmem_wdata_i;
    logic [DATA_WIDTH-1:0] dmem_rdata_o;
    logic                  dmem_ack_o;
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;
    logic                  mem_ack_i;
    logic                  err_o;
    logic                  busy_o;

    modport slave (
        input  imem_req_i, imem_addr_i, dmem_req_i, dmem_we_i, dmem_addr_i, dmem_wdata_i,
        input  mem_rdata_i, mem_ack_i,
        output imem_rdata_o, imem_ack_o, dmem_rdata_o, dmem_ack_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o, busy_o
    );

    modport master (
        output imem_req_i, imem_addr_i, dmem_req_i, dmem_we_i, dmem_addr_i, dmem_wdata_i,
        output mem_rdata_i, mem_ack_i,
        input  imem_rdata_o, imem_ack_o, dmem_rdata_o, dmem_ack_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o, busy_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch and data ports,
// with a registered req/ack handshake and a wait-state timeout that returns an error.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic GRANT_INSTR = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;

    state_t                state_reg, state_next;
    logic                  last_grant_reg, last_grant_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic                  we_reg, we_next;
    logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic [DATA_WIDTH-1:0] irdata_reg, irdata_next;
    logic [DATA_WIDTH-1:0] drdata_reg, drdata_next;
    logic                  err_reg, err_next;
    logic                  pick_data;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg      <= IDLE;
            last_grant_reg <= GRANT_INSTR;
            cnt_reg        <= '0;
            addr_reg       <= '0;
            we_reg         <= 1'b0;
            wdata_reg      <= '0;
            irdata_reg     <= '0;
            drdata_reg     <= '0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            cnt_reg        <= cnt_next;
            addr_reg       <= addr_next;
            we_reg         <= we_next;
            wdata_reg      <= wdata_next;
            irdata_reg     <= irdata_next;
            drdata_reg     <= drdata_next;
            err_reg        <= err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        cnt_next        = cnt_reg;
        addr_next       = addr_reg;
        we_next         = we_reg;
        wdata_next      = wdata_reg;
        irdata_next     = irdata_reg;
        drdata_next     = drdata_reg;
        err_next        = err_reg;
        // Data wins a tie whenever fetch held the previous grant.
        pick_data       = bus.dmem_req_i && (!bus.imem_req_i || last_grant_reg == GRANT_INSTR);
        case (state_reg)
            IDLE: begin
                if (bus.imem_req_i || bus.dmem_req_i) begin
                    cnt_next = '0;
                    err_next = 1'b0;
                    if (pick_data) begin
                        state_next      = GNT_D;
                        last_grant_next = GRANT_DATA;
                        addr_next       = bus.dmem_addr_i;
                        we_next         = bus.dmem_we_i;
                        wdata_next      = bus.dmem_wdata_i;
                    end else begin
                        state_next      = GNT_I;
                        last_grant_next = GRANT_INSTR;
                        addr_next       = bus.imem_addr_i;
                        we_next         = 1'b0;
                    end
                end
            end
            GNT_I, GNT_D: begin
                if (bus.mem_ack_i) begin
                    state_next = RESP;
                    err_next   = 1'b0;
                    if (state_reg == GNT_I) irdata_next = bus.mem_rdata_i;
                    else                    drdata_next = bus.mem_rdata_i;
                end else if (TIMEOUT_CYCLES != 0 && cnt_reg == CNT_LIMIT) begin
                    state_next = RESP;
                    err_next   = 1'b1;
                    if (state_reg == GNT_I) irdata_next = '0;
                    else                    drdata_next = '0;
                end else if (cnt_reg != CNT_MAX) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            RESP: begin
                state_next = IDLE;
                err_next   = 1'b0;
            end
            default: state_next = IDLE;
        endcase
    end

    // Every output is a register or a decode of registered state.
    assign bus.mem_req_o    = (state_reg == GNT_I) || (state_reg == GNT_D);
    assign bus.mem_we_o     = we_reg;
    assign bus.mem_addr_o   = addr_reg;
    assign bus.mem_wdata_o  = wdata_reg;
    assign bus.imem_ack_o   = (state_reg == RESP) && (last_grant_reg == GRANT_INSTR);
    assign bus.dmem_ack_o   = (state_reg == RESP) && (last_grant_reg == GRANT_DATA);
    assign bus.imem_rdata_o = irdata_reg;
    assign bus.dmem_rdata_o = drdata_reg;
    assign bus.err_o        = err_reg;
    assign bus.busy_o       = (state_reg != IDLE);
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the processor's instruction-fetch port and its data-access port.
- Sits between the simple_processor imem_*/dmem_* buses and the unified memory.
- Round-robin arbitration, a registered request/acknowledge handshake, and a wait-state timeout that returns an error response.
- Lets the core run with one physical memory and turns its fixed-request fetch into a proper handshake.

Parameters:
ADDR_WIDTH, simple_processor_pkg::ADDR_WIDTH, width of all address buses
DATA_WIDTH, simple_processor_pkg::DATA_WIDTH, width of all data buses
TIMEOUT_CYCLES, 16, maximum cycles mem_req_o is held without mem_ack_i; 0 disables the timeout

Ports:
clk_i  in  1  single global clock, rising edge
rst_ni  in  1  reset, synchronous, active-low
imem_req_i  in  1  fetch request, held until imem_ack_o
imem_addr_i  in  ADDR_WIDTH  fetch address
imem_rdata_o  out  DATA_WIDTH  fetch read data, valid with imem_ack_o
imem_ack_o  out  1  one-cycle fetch completion pulse
dmem_req_i  in  1  data request, held until dmem_ack_o
dmem_we_i  in  1  1 = write, 0 = read
dmem_addr_i  in  ADDR_WIDTH  data address
dmem_wdata_i  in  DATA_WIDTH  write data
dmem_rdata_o  out  DATA_WIDTH  data read data, valid with dmem_ack_o
dmem_ack_o  out  1  one-cycle data completion pulse
mem_req_o  out  1  request to the shared memory
mem_we_o  out  1  write enable to the shared memory
mem_addr_o  out  ADDR_WIDTH  shared memory address
mem_wdata_o  out  DATA_WIDTH  shared memory write data
mem_rdata_i  in  DATA_WIDTH  shared memory read data, valid with mem_ack_i
mem_ack_i  in  1  shared memory completion
err_o  out  1  high with the ack pulse when the transaction timed out
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset: clk_i is the only clock; rst_ni is synchronous and active-low. While rst_ni = 0 at a clock edge:
  - state goes to IDLE; last_grant goes to INSTR; timeout counter clears.
  - All outputs go to 0, including rdata outputs.
  - Reset mid-transaction abandons it with no ack pulse to the requester.
- State machine: IDLE, GNT_I, GNT_D, RESP. All outputs are registered or decoded from state only; there is no combinational path from an input to an output.
- IDLE:
  - Only imem_req_i -> GNT_I.
  - Only dmem_req_i -> GNT_D.
  - Both -> grant the port that was not granted last (last_grant INSTR means data wins).
  - On entry to GNT_x, latch the chosen port's address into mem_addr_o (plus we/wdata for data; mem_we_o = 0 for fetch), update last_grant, and clear the counter.
- GNT_I / GNT_D:
  - mem_req_o = 1 and the latched address/we/wdata are held stable.
  - Requester inputs are ignored; changes during the grant have no effect.
  - mem_ack_i = 1: capture mem_rdata_i into the granted port's rdata_o, go to RESP with ack to that port.
  - Otherwise, if TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1: go to RESP with err = 1 and rdata_o = 0.
  - Otherwise the counter increments.
- RESP:
  - Exactly one cycle; mem_req_o = 0.
  - Granted port's ack_o = 1; err_o = 1 only for the timeout case. The other port's ack_o = 0.
  - Next state is always IDLE. New requests are not sampled in RESP; requesters drop req on the edge after seeing ack.
- rdata_o holds its last value until the next ack to that port.
- Latency:
  - req high in IDLE at edge N -> mem_req_o high from cycle N+1.
  - mem_ack_i seen at edge M -> ack_o high during cycle M+1.
  - Minimum transaction 3 cycles, IDLE-to-IDLE.
- Back-to-back on one port: at least 1 idle cycle (IDLE) between transactions.
- Contention: under sustained requests on both ports, grants alternate strictly I, D, I, D.
- mem_ack_i is ignored in IDLE and RESP, with no state change.
- Timeout counter width is clog2(TIMEOUT_CYCLES+1) and it never wraps. A mem_ack_i in the same cycle the counter hits its limit counts as a normal ack: err_o = 0.
- busy_o = (state != IDLE).

Test Plan:
- Single fetch: imem_req_i = 1, addr 0x0010; memory acks 2 cycles after mem_req_o with 0xA5A5 -> mem_addr_o = 0x0010, mem_we_o = 0; imem_ack_o one cycle with imem_rdata_o = 0xA5A5; dmem_ack_o stays 0; err_o = 0.
- Data write: dmem_req_i = 1, we = 1, addr 0x0040, wdata 0x1234; zero-wait ack (mem_ack_i high in the first mem_req_o cycle) -> mem_we_o = 1, mem_wdata_o = 0x1234; dmem_ack_o pulses exactly 2 cycles after the request is sampled; transaction is 3 cycles.
- Contention: both ports requesting continuously for 4 transactions after reset -> grant order D, I, D, I; mem_addr_o matches the granted port each time; never two acks in one cycle.
- Timeout: dmem read with mem_ack_i never asserted, TIMEOUT_CYCLES = 16 -> mem_req_o high for exactly 16 cycles, then dmem_ack_o = 1, err_o = 1, dmem_rdata_o = 0; next fetch completes normally with err_o = 0.
- Reset mid-transaction: rst_ni low for one edge during GNT_I -> next cycle all outputs 0, busy_o = 0, no imem_ack_o; a later imem request is serviced normally, and a simultaneous dmem request wins (last_grant reset to INSTR).
- Ack-at-limit race: mem_ack_i asserted in the 16th wait cycle with 0x00FF -> normal ack, err_o = 0, rdata_o = 0x00FF.
